// File: rtl/conv3x3_engine_pkg.sv
// Shared geometry, widths, FSM encoding and the output clamp for the 3x3 convolution engine.
package conv3x3_engine_pkg;

    localparam int IMG_N = 6;
    localparam int K     = 3;
    localparam int WGT_W = 4;
    localparam int ACC_W = 8;
    localparam int OUT_W = 4;
    localparam int OUT_N = IMG_N - K + 1;
    localparam int TAPS  = K * K;
    localparam int NRES  = OUT_N * OUT_N;
    localparam int IDX_W = 4;
    localparam int TAP_W = 4;
    localparam int POS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OUT_W) - 1);

    // ReLU followed by saturation to the unsigned result range.
    function automatic logic [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] s);
        if (s < 0)
            return '0;
        else if (s > SAT_MAX)
            return '1;
        else
            return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/conv3x3_engine_tap_sel.sv
// Combinational selection of the image pixel and kernel weight addressed by (orow, ocol, tap).
module conv3x3_engine_tap_sel
    import conv3x3_engine_pkg::*;
(
    input  logic [IMG_N*IMG_N-1:0]  img,
    input  logic [K*K*WGT_W-1:0]    kernel,
    input  logic [POS_W-1:0]        orow,
    input  logic [POS_W-1:0]        ocol,
    input  logic [TAP_W-1:0]        tap,
    output logic                    pix,
    output logic signed [WGT_W-1:0] wgt
);

    logic [WGT_W-1:0] w_arr [TAPS];
    logic [1:0]       kr;
    logic [1:0]       kc;
    logic [2:0]       row;
    logic [2:0]       col;
    logic [5:0]       pidx;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_unpack
            assign w_arr[gi] = kernel[gi*WGT_W +: WGT_W];
        end
    endgenerate

    // Decode tap into kernel row/column, then address the pixel and weight.
    always_comb begin
        kr  = '0;
        kc  = '0;
        wgt = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (tap == TAP_W'(i)) begin
                kr  = 2'(i / K);
                kc  = 2'(i % K);
                wgt = w_arr[i];
            end
        end
        row  = {1'b0, orow} + {1'b0, kr};
        col  = {1'b0, ocol} + {1'b0, kc};
        pidx = 6'(row) * 6'(IMG_N) + 6'(col);
        pix  = img[pidx];
    end

endmodule

// File: rtl/conv3x3_engine.sv
// Sequential 3x3 valid-mode convolution over a latched 6x6 binary image, one MAC per cycle,
// results streamed out in raster order over a valid/ready port.
module conv3x3_engine
    import conv3x3_engine_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IMG_N*IMG_N-1:0] img_in,
    input  logic [K*K*WGT_W-1:0]   kernel_in,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   done
);

    state_t                   state_reg, state_next;
    logic [IMG_N*IMG_N-1:0]   img_reg;
    logic [K*K*WGT_W-1:0]     ker_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [TAP_W-1:0]         tap_reg;
    logic [POS_W-1:0]         orow_reg;
    logic [POS_W-1:0]         ocol_reg;
    logic [OUT_W-1:0]         out_data_reg;
    logic [IDX_W-1:0]         out_idx_reg;

    logic                     pix;
    logic signed [WGT_W-1:0]  wgt;
    logic signed [ACC_W-1:0]  wgt_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     last_tap;
    logic                     last_res;

    conv3x3_engine_tap_sel u_tap_sel (
        .img    (img_reg),
        .kernel (ker_reg),
        .orow   (orow_reg),
        .ocol   (ocol_reg),
        .tap    (tap_reg),
        .pix    (pix),
        .wgt    (wgt)
    );

    assign wgt_ext  = {{(ACC_W-WGT_W){wgt[WGT_W-1]}}, wgt};
    assign acc_sum  = acc_reg + (pix ? wgt_ext : '0);
    assign last_tap = (tap_reg == TAP_W'(TAPS - 1));
    assign last_res = (out_idx_reg == IDX_W'(NRES - 1));

    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = (state_reg == ST_EMIT);
    assign done      = (state_reg == ST_DONE);
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; DONE always returns to IDLE so a start there is never taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)     state_next = ST_MAC;
            ST_MAC:  if (last_tap)  state_next = ST_EMIT;
            ST_EMIT: if (out_ready) state_next = last_res ? ST_DONE : ST_MAC;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Datapath: frame latch, tap/position counters, accumulator and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_reg      <= '0;
            ker_reg      <= '0;
            acc_reg      <= '0;
            tap_reg      <= '0;
            orow_reg     <= '0;
            ocol_reg     <= '0;
            out_data_reg <= '0;
            out_idx_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        img_reg  <= img_in;
                        ker_reg  <= kernel_in;
                        acc_reg  <= '0;
                        tap_reg  <= '0;
                        orow_reg <= '0;
                        ocol_reg <= '0;
                    end
                end
                ST_MAC: begin
                    acc_reg <= acc_sum;
                    if (last_tap) begin
                        tap_reg      <= '0;
                        out_data_reg <= relu_sat(acc_sum);
                        out_idx_reg  <= {orow_reg, ocol_reg};
                    end else begin
                        tap_reg <= tap_reg + 1'b1;
                    end
                end
                ST_EMIT: begin
                    // 2-bit column counter wraps 3->0 on its own; row advances on that wrap.
                    if (out_ready && !last_res) begin
                        acc_reg  <= '0;
                        ocol_reg <= ocol_reg + 1'b1;
                        if (ocol_reg == POS_W'(OUT_N - 1))
                            orow_reg <= orow_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
